// File: rtl/csu_seq_ctrl.sv
// Power-up / ATB-scan sequencer for the current source units (Moore FSM, registered outputs).
// Optional test-bus scan is built only when CSU_SEQ_ATB_SCAN_EN is defined.
module csu_seq_ctrl #(
  parameter int unsigned SETTLE_CYC  = 64,
  parameter int unsigned TIMEOUT_CYC = 255,
  parameter int unsigned ATB_DWELL   = 16,
  parameter int unsigned CNT_W       = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       supply_ok,
  input  logic       iref_ok,
  input  logic       atb_start,
  input  logic       fault_clr,
  output logic       pdb,
  output logic [1:0] atb_ena,
  output logic       ready,
  output logic       atb_strobe,
  output logic       scan_done,
  output logic       fault,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_OFF      = 3'd0,
    S_WAIT_SUP = 3'd1,
    S_SETTLE   = 3'd2,
    S_READY    = 3'd3,
`ifdef CSU_SEQ_ATB_SCAN_EN
    S_ATB_SCAN = 3'd4,
`endif
    S_FAULT    = 3'd5
  } state_e;

  localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] DWELL_LAST   = CNT_W'(ATB_DWELL - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [1:0]       step_q, step_d;
  logic             pdb_q, pdb_d;
  logic [1:0]       atb_ena_q, atb_ena_d;
  logic             ready_q, ready_d;
  logic             strobe_q, strobe_d;
  logic             done_q, done_d;
  logic             fault_q, fault_d;
  logic             ok;

  assign ok      = supply_ok & iref_ok;
  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);

`ifndef CSU_SEQ_ATB_SCAN_EN
  logic [CNT_W:0] cfg_unused;
  assign cfg_unused = {atb_start, DWELL_LAST};
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_inc;
    step_d  = step_q;
    done_d  = 1'b0;
    case (state_q)
      S_OFF: begin
        if (en) state_d = S_WAIT_SUP;
      end
      // Supply loss here is the normal waiting condition, not a fault.
      S_WAIT_SUP: begin
        if (!en)                        state_d = S_OFF;
        else if (ok)                    state_d = S_SETTLE;
        else if (cnt_q >= TIMEOUT_LAST) state_d = S_FAULT;
      end
      S_SETTLE: begin
        if (!ok)                       state_d = S_FAULT;
        else if (!en)                  state_d = S_OFF;
        else if (cnt_q >= SETTLE_LAST) state_d = S_READY;
      end
      S_READY: begin
        if (!ok)       state_d = S_FAULT;
        else if (!en)  state_d = S_OFF;
`ifdef CSU_SEQ_ATB_SCAN_EN
        else if (atb_start) begin
          state_d = S_ATB_SCAN;
          step_d  = '0;
        end
`endif
      end
`ifdef CSU_SEQ_ATB_SCAN_EN
      S_ATB_SCAN: begin
        if (!ok)      state_d = S_FAULT;
        else if (!en) state_d = S_OFF;
        else if (cnt_q >= DWELL_LAST) begin
          if (step_q == 2'd2) begin
            state_d = S_READY;
            done_d  = 1'b1;
          end else begin
            step_d = step_q + 2'd1;
            cnt_d  = '0;
          end
        end
      end
`endif
      S_FAULT: begin
        if (fault_clr) state_d = S_OFF;
      end
      default: state_d = S_FAULT;
    endcase

    // Every state change starts the next phase with a cleared counter and step.
    if (state_d != state_q) begin
      cnt_d  = '0;
      step_d = '0;
    end

    pdb_d     = (state_d == S_SETTLE) || (state_d == S_READY);
    ready_d   = (state_d == S_READY);
    fault_d   = (state_d == S_FAULT);
    atb_ena_d = '0;
    strobe_d  = 1'b0;
`ifdef CSU_SEQ_ATB_SCAN_EN
    if (state_d == S_ATB_SCAN) begin
      pdb_d     = 1'b1;
      ready_d   = 1'b1;
      atb_ena_d = step_d + 2'd1;
      strobe_d  = (cnt_d == DWELL_LAST);
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_OFF;
      cnt_q     <= '0;
      step_q    <= '0;
      pdb_q     <= 1'b0;
      atb_ena_q <= '0;
      ready_q   <= 1'b0;
      strobe_q  <= 1'b0;
      done_q    <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      step_q    <= step_d;
      pdb_q     <= pdb_d;
      atb_ena_q <= atb_ena_d;
      ready_q   <= ready_d;
      strobe_q  <= strobe_d;
      done_q    <= done_d;
      fault_q   <= fault_d;
    end
  end

  assign pdb        = pdb_q;
  assign atb_ena    = atb_ena_q;
  assign ready      = ready_q;
  assign atb_strobe = strobe_q;
  assign scan_done  = done_q;
  assign fault      = fault_q;
  assign state      = state_q;

endmodule

// File: tb/tb_csu_seq_ctrl.sv
// Self-checking bench for csu_seq_ctrl: directed bring-up/timeout/scan/abort/reset
// scenarios followed by randomized segments, all against a phase/elapsed-time model.
module tb_csu_seq_ctrl;

  localparam int SETTLE = 64;
  localparam int TMO    = 255;
  localparam int DWELL  = 16;
`ifdef CSU_SEQ_ATB_SCAN_EN
  localparam bit SCAN = 1'b1;
`else
  localparam bit SCAN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst, en, supply_ok, iref_ok, atb_start, fault_clr;
  logic       pdb, ready, atb_strobe, scan_done, fault;
  logic [1:0] atb_ena;
  logic [2:0] state;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // Model: phase number (0..5 as named in the requirements) and cycles elapsed in it.
  int m_mode = 0;
  int m_el   = 0;
  bit m_done = 1'b0;

  csu_seq_ctrl #(.SETTLE_CYC(SETTLE), .TIMEOUT_CYC(TMO), .ATB_DWELL(DWELL), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .en(en), .supply_ok(supply_ok), .iref_ok(iref_ok),
    .atb_start(atb_start), .fault_clr(fault_clr), .pdb(pdb), .atb_ena(atb_ena),
    .ready(ready), .atb_strobe(atb_strobe), .scan_done(scan_done), .fault(fault),
    .state(state)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0;
    m_el   = 0;
    m_done = 1'b0;
  endtask

  task automatic enter(input int mode);
    m_mode = mode;
    m_el   = 0;
  endtask

  task automatic model_step();
    bit ok;
    ok     = supply_ok && iref_ok;
    m_done = 1'b0;
    case (m_mode)
      0: if (en) enter(1);
      1: if (!en) enter(0); else if (ok) enter(2); else if (m_el + 1 >= TMO) enter(5); else m_el++;
      2: if (!ok) enter(5); else if (!en) enter(0); else if (m_el + 1 >= SETTLE) enter(3); else m_el++;
      3: if (!ok) enter(5); else if (!en) enter(0); else if (atb_start && SCAN) enter(4);
      4: begin
        if (!ok) enter(5);
        else if (!en) enter(0);
        else if (m_el + 1 >= 3 * DWELL) begin enter(3); m_done = 1'b1; end
        else m_el++;
      end
      default: if (fault_clr) enter(0);
    endcase
  endtask

  task automatic check_outputs(input string ph);
    check({ph, ":state"}, state, m_mode);
    check({ph, ":pdb"}, pdb, (m_mode >= 2 && m_mode <= 4));
    check({ph, ":ready"}, ready, (m_mode == 3 || m_mode == 4));
    check({ph, ":fault"}, fault, (m_mode == 5));
    check({ph, ":atb_ena"}, atb_ena, (m_mode == 4) ? (m_el / DWELL + 1) : 0);
    check({ph, ":strobe"}, atb_strobe, (m_mode == 4) && (m_el % DWELL == DWELL - 1));
    check({ph, ":scan_done"}, scan_done, m_done);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_outputs("cyc");
  endtask

  // Called 1 time unit after an edge: asserts reset mid-cycle, releases before the next edge.
  task automatic async_reset();
    #2 rst = 1'b1;
    #1 model_reset();
    check_outputs("rst");
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic pulse_clr();
    fault_clr = 1'b1;
    tick();
    fault_clr = 1'b0;
  endtask

  task automatic goto_ready();
    en = 1'b1; supply_ok = 1'b1; iref_ok = 1'b1;
    for (int i = 0; i < 200 && m_mode != 3; i++) tick();
    check("reach_ready", state, 3);
  endtask

  initial begin
    int n;
    bit seen;
    int strobes[$];
    int done_at;

    rst = 1'b1; en = 1'b0; supply_ok = 1'b0; iref_ok = 1'b0; atb_start = 1'b0; fault_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1 check_outputs("por");
    @(negedge clk);
    rst = 1'b0;

    // Bring-up latency.
    en = 1'b1; supply_ok = 1'b1; iref_ok = 1'b1;
    n = 0;
    for (int i = 0; i < 10 && !pdb; i++) begin tick(); n++; end
    check("pdb_latency", n, 2);
    n = 0;
    for (int i = 0; i < 200 && !ready; i++) begin tick(); n++; end
    check("ready_latency", n, SETTLE);

    // Scan request: full scan with scan build, ignored otherwise.
    atb_start = 1'b1;
    tick();
    atb_start = 1'b0;
    done_at = 0;
    for (int i = 1; i <= 60; i++) begin
      if (i != 1) begin
        atb_start = (i == 20);
        tick();
      end
      if (atb_strobe) strobes.push_back(i);
      if (scan_done) done_at = i;
    end
    atb_start = 1'b0;
    if (SCAN) begin
      check("strobe_count", strobes.size(), 3);
      if (strobes.size() == 3) begin
        check("strobe0_pos", strobes[0], DWELL);
        check("strobe_gap1", strobes[1] - strobes[0], DWELL);
        check("strobe_gap2", strobes[2] - strobes[1], DWELL);
      end
      check("done_pos", done_at, 3 * DWELL + 1);
    end else begin
      check("no_strobes", strobes.size(), 0);
      check("no_done", done_at, 0);
    end
    check("post_scan_ena", atb_ena, 0);

    // Abort during step 1.
    if (SCAN) begin
      atb_start = 1'b1;
      tick();
      atb_start = 1'b0;
      repeat (DWELL + 3) tick();
      check("abort_in_step1", atb_ena, 2'b10);
      supply_ok = 1'b0;
      tick();
      check("abort_state", state, 5);
      check("abort_pdb", pdb, 0);
      check("abort_ena", atb_ena, 0);
      check("abort_done", scan_done, 0);
      supply_ok = 1'b1;
      repeat (3) tick();
      pulse_clr();
      check("abort_clr", state, 0);
    end

    // Timeout in WAIT_SUP; en/ok ignored once in FAULT.
    goto_ready();
    en = 1'b0;
    tick();
    en = 1'b1; supply_ok = 1'b0;
    tick();
    check("wait_entered", state, 1);
    n = 0; seen = 1'b0;
    for (int i = 0; i < 400 && !fault; i++) begin
      tick(); n++;
      seen |= pdb;
    end
    check("timeout_cycles", n, TMO);
    check("timeout_pdb_never", seen, 0);
    supply_ok = 1'b1;
    en = 1'b0;
    repeat (4) tick();
    check("fault_sticky", fault, 1);
    pulse_clr();
    check("fault_clr_off", state, 0);
    check("fault_clr_flag", fault, 0);

    // Supply loss outranks en=0.
    goto_ready();
    en = 1'b0; iref_ok = 1'b0;
    tick();
    check("prio_fault", state, 5);
    iref_ok = 1'b1;
    pulse_clr();

    // Async reset in SETTLE, then en must be resampled.
    en = 1'b1;
    repeat (12) tick();
    check("in_settle", state, 2);
    async_reset();
    tick();
    check("restart_wait", state, 1);

    // Randomized segments.
    for (int s = 0; s < 60; s++) begin
      int len;
      len       = $urandom_range(1, 300);
      en        = ($urandom_range(0, 9) != 0);
      supply_ok = ($urandom_range(0, 7) != 0);
      iref_ok   = ($urandom_range(0, 7) != 0);
      for (int c = 0; c < len; c++) begin
        atb_start = ($urandom_range(0, 29) == 0);
        fault_clr = ($urandom_range(0, 19) == 0);
        tick();
        if ($urandom_range(0, 1999) == 0) async_reset();
      end
    end
    atb_start = 1'b0;
    fault_clr = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
